// File: rtl/fire2_pkg.sv
// Shared types and default sizes for the fire2 squeeze-to-expand serializer.
package fire2_pkg;
    localparam int FIRE2_WIDTH  = 16;
    localparam int FIRE2_DSP_NO = 16;

    typedef logic signed [FIRE2_WIDTH-1:0] word_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_DONE
    } send_state_t;
endpackage

// File: rtl/fire2_pingpong_bank.sv
// One DSP_NO-word holding bank: parallel load, full flag, indexed read.
module fire2_pingpong_bank
    import fire2_pkg::*;
#(
    parameter int DSP_NO = FIRE2_DSP_NO,
    parameter int WIDTH  = FIRE2_WIDTH,
    localparam int CW    = (DSP_NO > 1) ? $clog2(DSP_NO) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic             unload,
    input  logic [WIDTH-1:0] load_data [0:DSP_NO-1],
    input  logic [CW-1:0]    rd_idx,
    output logic             full,
    output logic [WIDTH-1:0] rd_data
);
    logic [WIDTH-1:0] mem_reg [0:DSP_NO-1];
    logic             full_reg;

    always_ff @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < DSP_NO; i++) begin
                mem_reg[i] <= load_data[i];
            end
        end
    end

    // A load on the same edge as the unload refills the bank, so load wins.
    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            full_reg <= 1'b0;
        end else if (load) begin
            full_reg <= 1'b1;
        end else if (unload) begin
            full_reg <= 1'b0;
        end
    end

    assign full    = full_reg;
    assign rd_data = mem_reg[rd_idx];
endmodule

// File: rtl/fire2_squeeze_serializer.sv
// Ping-pong capture of squeeze outputs, serialized one word per cycle to the expand stage.
// Optional clamp of negative words when FIRE2_RELU_EN is defined.
module fire2_squeeze_serializer
    import fire2_pkg::*;
#(
    parameter int DSP_NO = FIRE2_DSP_NO,
    parameter int WIDTH  = FIRE2_WIDTH,
    parameter int W_OUT  = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             layer_en,
    input  logic             sample_in,
    input  logic [WIDTH-1:0] ofm_in [0:DSP_NO-1],
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             layer_done,
    output logic             overflow
);
    localparam int TOTAL = W_OUT * W_OUT;
    localparam int PW    = $clog2(TOTAL + 1);
    localparam int CW    = (DSP_NO > 1) ? $clog2(DSP_NO) : 1;
    localparam logic [CW-1:0] CH_LAST = CW'(DSP_NO - 1);

    send_state_t      state_reg;
    logic [CW-1:0]    ch_reg;
    logic [PW-1:0]    pix_cnt_reg;
    logic             wr_sel_reg;
    logic             rd_sel_reg;
    logic [WIDTH-1:0] out_data_reg;
    logic             out_valid_reg;
    logic             layer_done_reg;
    logic             overflow_reg;

    logic [WIDTH-1:0] relu_data [0:DSP_NO-1];
    logic             bank_full [0:1];
    logic [WIDTH-1:0] bank_data [0:1];
    logic             bank_load [0:1];
    logic             bank_unload [0:1];
    logic [CW-1:0]    bank_idx [0:1];

    logic             xfer;
    logic             last_xfer;
    logic             cap_req;
    logic             wr_free;
    logic             cap;
    logic             drop;
    logic             other_sel;
    logic [PW-1:0]    pix_next;

    genvar gi;
    generate
        for (gi = 0; gi < DSP_NO; gi++) begin : g_relu
`ifdef FIRE2_RELU_EN
            assign relu_data[gi] = ofm_in[gi][WIDTH-1] ? '0 : ofm_in[gi];
`else
            assign relu_data[gi] = ofm_in[gi];
`endif
        end
    endgenerate

    assign xfer      = out_valid_reg && out_ready && (state_reg == S_SEND);
    assign last_xfer = xfer && (ch_reg == CH_LAST);
    assign cap_req   = sample_in && layer_en && !layer_done_reg;
    // The capture bank may be the one whose last word leaves on this very edge.
    assign wr_free   = !bank_full[wr_sel_reg] || (last_xfer && (rd_sel_reg == wr_sel_reg));
    assign cap       = cap_req && wr_free;
    assign drop      = cap_req && !wr_free;
    assign other_sel = ~rd_sel_reg;
    assign pix_next  = pix_cnt_reg + 1'b1;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            assign bank_load[gi]   = cap && (wr_sel_reg == 1'(gi));
            assign bank_unload[gi] = last_xfer && (rd_sel_reg == 1'(gi));
            // The sending bank is looked up one word ahead; the other bank always at word 0.
            assign bank_idx[gi]    = (state_reg == S_SEND && rd_sel_reg == 1'(gi))
                                     ? CW'(ch_reg + 1'b1) : '0;

            fire2_pingpong_bank #(
                .DSP_NO (DSP_NO),
                .WIDTH  (WIDTH)
            ) u_bank (
                .clk       (clk),
                .rst       (rst),
                .clear     (!layer_en),
                .load      (bank_load[gi]),
                .unload    (bank_unload[gi]),
                .load_data (relu_data),
                .rd_idx    (bank_idx[gi]),
                .full      (bank_full[gi]),
                .rd_data   (bank_data[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst || !layer_en) begin
            state_reg      <= S_IDLE;
            ch_reg         <= '0;
            pix_cnt_reg    <= '0;
            wr_sel_reg     <= 1'b0;
            rd_sel_reg     <= 1'b0;
            out_data_reg   <= '0;
            out_valid_reg  <= 1'b0;
            layer_done_reg <= 1'b0;
            overflow_reg   <= 1'b0;
        end else begin
            if (cap) begin
                wr_sel_reg <= ~wr_sel_reg;
            end
            if (drop) begin
                overflow_reg <= 1'b1;
            end
            case (state_reg)
                S_IDLE: begin
                    if (bank_full[rd_sel_reg]) begin
                        state_reg     <= S_SEND;
                        ch_reg        <= '0;
                        out_valid_reg <= 1'b1;
                        out_data_reg  <= bank_data[rd_sel_reg];
                    end
                end
                S_SEND: begin
                    if (xfer) begin
                        if (ch_reg != CH_LAST) begin
                            ch_reg       <= ch_reg + 1'b1;
                            out_data_reg <= bank_data[rd_sel_reg];
                        end else begin
                            rd_sel_reg  <= other_sel;
                            pix_cnt_reg <= pix_next;
                            ch_reg      <= '0;
                            if (pix_next == PW'(TOTAL)) begin
                                state_reg      <= S_DONE;
                                out_valid_reg  <= 1'b0;
                                layer_done_reg <= 1'b1;
                            end else if (bank_full[other_sel]) begin
                                out_data_reg <= bank_data[other_sel];
                            end else begin
                                state_reg     <= S_IDLE;
                                out_valid_reg <= 1'b0;
                            end
                        end
                    end
                end
                S_DONE: begin
                    out_valid_reg <= 1'b0;
                end
                default: begin
                    state_reg     <= S_IDLE;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign out_data   = out_data_reg;
    assign out_valid  = out_valid_reg;
    assign layer_done = layer_done_reg;
    assign overflow   = overflow_reg;
endmodule

// File: doc/fire2_squeeze_serializer.md
# fire2_squeeze_serializer

Downstream companion of the fire2 squeeze convolution stage. It captures the DSP_NO parallel output words that the squeeze stage presents on each sample pulse and double-buffers them in two ping-pong banks. It optionally applies ReLU, then streams the words one per cycle to the fire2 expand stages over a valid/ready handshake. It also counts pixels, raises a layer-done flag once the whole squeeze feature map has been forwarded, and flags any sample lost to back-pressure.

## Interface
Parameters:
- DSP_NO, 16, parallel words per sample (one per squeeze DSP/output channel)
- WIDTH, 16, word width (signed fixed point)
- W_OUT, 64, squeeze output feature-map width = height; pixels per layer = W_OUT*W_OUT

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- layer_en  in  1  layer enable; low holds the block idle and clears done/overflow/counters
- sample_in  in  1  one-cycle pulse from squeeze stage, ofm_in valid this cycle
- ofm_in  in  DSP_NO x WIDTH  unpacked array [0:DSP_NO-1] of squeeze results
- out_data  out  WIDTH  serialized word to expand stage
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts when out_valid && out_ready
- layer_done  out  1  all W_OUT*W_OUT*DSP_NO words transferred
- overflow  out  1  sticky, a sample arrived with both banks occupied

## Operation
- Two banks, each with DSP_NO words plus a full flag. wr_sel selects the capture bank and rd_sel the send bank; both toggle after use.
- Capture: when sample_in && layer_en && !layer_done and bank[wr_sel] is free, or is freed on this same edge, store ofm_in (ReLU-processed), set full, and toggle wr_sel.
- Capture with both banks full and neither freeing: drop the sample, set overflow, and do not advance the pixel count.
- Send FSM:
  - S_IDLE: go to S_SEND when bank[rd_sel] is full.
  - S_SEND: present bank[rd_sel][ch] with ch = 0..DSP_NO-1, ofm_in[0] first, advancing ch on each transfer.
  - On transfer of ch = DSP_NO-1: clear full, toggle rd_sel, increment pix_cnt.
  - If pix_cnt reaches W_OUT*W_OUT, go to S_DONE. Otherwise go to S_SEND if the other bank is full, else S_IDLE.
  - S_DONE: layer_done = 1, out_valid = 0, captures ignored; go to S_IDLE when layer_en is low.
- Handshake: out_data/out_valid are registered and held stable while out_valid && !out_ready. out_valid never drops without a transfer.
- layer_en low in any state: return to S_IDLE, clear banks, pointers, counters, layer_done, overflow, and out_valid.
- Arithmetic: pix_cnt width is $clog2(W_OUT*W_OUT+1); ch width is $clog2(DSP_NO). No wrap-around; the counters saturate by leaving S_SEND.

## Timing
- Reset (rst low at clk edge): out_data = 0, out_valid = 0, layer_done = 0, overflow = 0, banks empty, wr_sel = rd_sel = 0, state S_IDLE.
- Latency: sample captured at edge N from S_IDLE gives out_valid = 1 with word 0 after edge N+1.
- Throughput: with out_ready held high, one word per cycle. Back-to-back banks stream with no bubble. Sustained input rate is one sample per DSP_NO cycles.
- layer_done rises the cycle after the final transfer edge.
- overflow rises the cycle after the dropped sample.

## Configuration
- FIRE2_RELU_EN defined: each captured word is clamped, negative (MSB = 1) to 0, otherwise passed unchanged.
- FIRE2_RELU_EN undefined: words are stored and forwarded unchanged.

## Structure
- Package fire2_pkg holds:
  - WIDTH and DSP_NO defaults
  - typedef logic signed [WIDTH-1:0] word_t
  - enum send_state_t {S_IDLE, S_SEND, S_DONE}
- Sub-module fire2_pingpong_bank: one DSP_NO-word bank with load, full flag, and indexed read. Instantiated twice.
- Top level holds the pointers, the send FSM, the pixel counter, and the ReLU generate under FIRE2_RELU_EN.

## Test plan
- Single sample, ofm_in[i] = i+1, out_ready = 1 → out_data 1..16 on 16 consecutive cycles starting the cycle after capture; pix_cnt = 1.
- ReLU check, ofm_in[3] = 16'hFF00: with FIRE2_RELU_EN, word 3 = 0; without it, word 3 = 16'hFF00.
- Back-pressure: out_ready toggled 1,0,0,1 across the stream → out_data held constant during stalls, no word lost or duplicated.
- Overflow: out_ready = 0, three samples spaced 2 cycles apart → first two banks filled, overflow = 1, third sample dropped; after release, 32 words from samples 1 and 2 only.
- Full layer with W_OUT = 4 and out_ready = 1, sample every 16 cycles → 256 words, layer_done = 1 the cycle after the last transfer, further samples ignored.
- layer_en dropped mid-stream at word 7, then rst low for one cycle → out_valid = 0 and layer_done = overflow = 0 next cycle; restart produces word 0 of the next new sample.
